// File: rtl/text_cursor_writer.sv
// text_cursor_writer
// Turns a byte-wide console stream into cell writes for the character
// processor's text buffer. It tracks an 80x30 cursor, writes printable
// glyphs, and handles newline, carriage return, backspace and form feed.
//
// Optional feature macro: TEXT_WRAP_CLEAR_EN
//   When defined, every row advance (newline or column overflow) blanks the
//   newly entered row through the CLR_LINE state. When undefined, row
//   advances only move the cursor and the CLR_LINE state is not built.
//
// Write port timing: new_char/waddr/text_en are registered. A byte accepted
// on edge N presents its first write in the cycle after edge N. Multi-cycle
// clears then stream one blank per cycle with no gaps, and char_ready is
// raised so that a byte accepted in the first ready cycle follows the last
// blank write directly.

module text_cursor_writer #(
  parameter int unsigned COLS        = 80,
  parameter int unsigned ROWS        = 30,
  parameter logic [3:0]  BLANK_GLYPH = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [3:0]  new_char,
  output logic [11:0] waddr,
  output logic        text_en,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  // State encoding kept as plain constants for legacy tool compatibility.
  localparam logic [1:0] ST_IDLE       = 2'd0;
`ifdef TEXT_WRAP_CLEAR_EN
  localparam logic [1:0] ST_CLR_LINE   = 2'd1;
`endif
  localparam logic [1:0] ST_CLR_SCREEN = 2'd2;

  // Geometry constants at the widths used in the datapath.
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [11:0] COLS_W    = 12'(COLS);
  localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);

  // Control bytes understood by the decoder.
  localparam logic [7:0] BYTE_NL = 8'h0A;
  localparam logic [7:0] BYTE_CR = 8'h0D;
  localparam logic [7:0] BYTE_BS = 8'h08;
  localparam logic [7:0] BYTE_FF = 8'h0C;

  // Printable ASCII range that produces a glyph write.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  // Registered state.
  logic [1:0]  state_r;
  logic        ready_r;
  logic [6:0]  col_r;
  logic [4:0]  row_r;
  logic [11:0] base_r;      // row_r * COLS, maintained incrementally
  logic [11:0] clr_addr_r;  // next address to blank during a screen clear
  logic [3:0]  new_char_r;
  logic [11:0] waddr_r;
  logic        text_en_r;
`ifdef TEXT_WRAP_CLEAR_EN
  logic [6:0]  clr_col_r;   // next column to blank during a line clear
  logic [6:0]  clr_col_nxt_s;
`endif

  // Next-state values.
  logic [1:0]  state_nxt_s;
  logic        ready_nxt_s;
  logic [6:0]  col_nxt_s;
  logic [4:0]  row_nxt_s;
  logic [11:0] base_nxt_s;
  logic [11:0] clr_addr_nxt_s;
  logic [3:0]  new_char_nxt_s;
  logic [11:0] waddr_nxt_s;
  logic        text_en_nxt_s;

  // Helper values derived from the current cursor.
  logic        accept_s;
  logic [11:0] cell_s;
  logic [11:0] adv_base_s;
  logic [4:0]  adv_row_s;

  assign accept_s = char_valid & ready_r;
  assign cell_s   = base_r + {5'd0, col_r};

  // Row advance target: wrap to row 0 from the last row, no scrolling.
  always_comb begin
    if (row_r == LAST_ROW) begin
      adv_row_s  = 5'd0;
      adv_base_s = 12'd0;
    end else begin
      adv_row_s  = row_r + 5'd1;
      adv_base_s = base_r + COLS_W;
    end
  end

  // Byte decode, clear sequencing and next write-port values.
  always_comb begin
    state_nxt_s    = state_r;
    col_nxt_s      = col_r;
    row_nxt_s      = row_r;
    base_nxt_s     = base_r;
    clr_addr_nxt_s = clr_addr_r;
`ifdef TEXT_WRAP_CLEAR_EN
    clr_col_nxt_s  = clr_col_r;
`endif
    new_char_nxt_s = new_char_r;
    waddr_nxt_s    = waddr_r;
    text_en_nxt_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (is_printable(char_in)) begin
            text_en_nxt_s  = 1'b1;
            waddr_nxt_s    = cell_s;
            new_char_nxt_s = char_in[3:0];
            if (col_r == LAST_COL) begin
              col_nxt_s  = 7'd0;
              row_nxt_s  = adv_row_s;
              base_nxt_s = adv_base_s;
`ifdef TEXT_WRAP_CLEAR_EN
              // Blanks start in the cycle after the glyph write.
              state_nxt_s   = ST_CLR_LINE;
              clr_col_nxt_s = 7'd0;
`endif
            end else begin
              col_nxt_s = col_r + 7'd1;
            end
          end else begin
            case (char_in)
              BYTE_NL: begin
                col_nxt_s  = 7'd0;
                row_nxt_s  = adv_row_s;
                base_nxt_s = adv_base_s;
`ifdef TEXT_WRAP_CLEAR_EN
                // First blank goes out right away; the rest follow in CLR_LINE.
                text_en_nxt_s  = 1'b1;
                waddr_nxt_s    = adv_base_s;
                new_char_nxt_s = BLANK_GLYPH;
                state_nxt_s    = ST_CLR_LINE;
                clr_col_nxt_s  = 7'd1;
`endif
              end
              BYTE_CR: begin
                col_nxt_s = 7'd0;
              end
              BYTE_BS: begin
                if (col_r != 7'd0) begin
                  col_nxt_s      = col_r - 7'd1;
                  text_en_nxt_s  = 1'b1;
                  waddr_nxt_s    = cell_s - 12'd1;
                  new_char_nxt_s = BLANK_GLYPH;
                end else begin
                  col_nxt_s = col_r;
                end
              end
              BYTE_FF: begin
                // Cell 0 is blanked immediately; CLR_SCREEN continues from 1.
                col_nxt_s      = 7'd0;
                row_nxt_s      = 5'd0;
                base_nxt_s     = 12'd0;
                text_en_nxt_s  = 1'b1;
                waddr_nxt_s    = 12'd0;
                new_char_nxt_s = BLANK_GLYPH;
                state_nxt_s    = ST_CLR_SCREEN;
                clr_addr_nxt_s = 12'd1;
              end
              default: begin
                // Unrecognised control byte: consumed without effect.
                col_nxt_s = col_r;
              end
            endcase
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

`ifdef TEXT_WRAP_CLEAR_EN
      ST_CLR_LINE: begin
        text_en_nxt_s  = 1'b1;
        waddr_nxt_s    = base_r + {5'd0, clr_col_r};
        new_char_nxt_s = BLANK_GLYPH;
        if (clr_col_r == LAST_COL) begin
          state_nxt_s = ST_IDLE;
        end else begin
          clr_col_nxt_s = clr_col_r + 7'd1;
        end
      end
`endif

      ST_CLR_SCREEN: begin
        text_en_nxt_s  = 1'b1;
        waddr_nxt_s    = clr_addr_r;
        new_char_nxt_s = BLANK_GLYPH;
        if (clr_addr_r == LAST_CELL) begin
          state_nxt_s = ST_IDLE;
        end else begin
          clr_addr_nxt_s = clr_addr_r + 12'd1;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    ready_nxt_s = (state_nxt_s == ST_IDLE);
  end

  // State, cursor and write-port registers; reset aborts any clear at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ready_r    <= 1'b1;
      col_r      <= 7'd0;
      row_r      <= 5'd0;
      base_r     <= 12'd0;
      clr_addr_r <= 12'd0;
`ifdef TEXT_WRAP_CLEAR_EN
      clr_col_r  <= 7'd0;
`endif
      new_char_r <= 4'h0;
      waddr_r    <= 12'd0;
      text_en_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ready_r    <= ready_nxt_s;
      col_r      <= col_nxt_s;
      row_r      <= row_nxt_s;
      base_r     <= base_nxt_s;
      clr_addr_r <= clr_addr_nxt_s;
`ifdef TEXT_WRAP_CLEAR_EN
      clr_col_r  <= clr_col_nxt_s;
`endif
      new_char_r <= new_char_nxt_s;
      waddr_r    <= waddr_nxt_s;
      text_en_r  <= text_en_nxt_s;
    end
  end

  assign char_ready = ready_r;
  assign busy       = ~ready_r;
  assign new_char   = new_char_r;
  assign waddr      = waddr_r;
  assign text_en    = text_en_r;
  assign cursor_col = col_r;
  assign cursor_row = row_r;

endmodule

// File: doc/text_cursor_writer.md
# text_cursor_writer

Terminal-style front end that turns the CPU's byte-wide console output into cell writes for the character processor's text buffer. It accepts bytes over a valid/ready handshake and maintains an 80×30 cursor. It writes printable glyphs at the cursor and handles newline, carriage return, backspace and form feed. It drives the `new_char`/`waddr`/`text_en` write port of `character_processor` directly.

## Interface
- `COLS`, 80: columns per row (640 px / 8 px cells).
- `ROWS`, 30: rows per screen (480 px / 16 px cells).
- `BLANK_GLYPH`, 4'h0: glyph code written by clears and backspace.

- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `char_in`  in  8  byte from CPU.
- `char_valid`  in  1  `char_in` is valid.
- `char_ready`  out  1  block can accept a byte this cycle.
- `new_char`  out  4  glyph code to the text buffer.
- `waddr`  out  12  cell address, `row*COLS + col`, range 0..2399.
- `text_en`  out  1  write strobe to the text buffer.
- `cursor_col`  out  7  current column, 0..COLS-1.
- `cursor_row`  out  5  current row, 0..ROWS-1.
- `busy`  out  1  a multi-cycle clear is in progress; equals `~char_ready`.

## Operation
- **States:**
  - IDLE: `char_ready`=1.
  - CLR_LINE: blanks one row.
  - CLR_SCREEN: blanks all cells.
- **Acceptance:** a byte is accepted on a rising edge with `char_valid & char_ready`. Only IDLE accepts.
- **Byte decode:**
  - 0x20–0x7E printable: glyph = `char_in[3:0]`. The glyph is written at the cursor, then `col`+1.
  - 0x0A newline: `col`=0, `row`+1.
  - 0x0D carriage return: `col`=0. No write.
  - 0x08 backspace:
    - If `col`>0: `col`−1, then `BLANK_GLYPH` is written at the new position.
    - If `col`=0: no-op. There is no wrap to the previous row.
  - 0x0C form feed: enter CLR_SCREEN. The cursor goes to (0,0).
  - Any other byte: consumed and ignored. No write, cursor unchanged.
- **Column overflow:** a printable byte at `col`=COLS-1 is written there. The cursor then moves to `col`=0, `row`+1.
- **Row advance:** at `row`=ROWS-1, any row advance wraps to `row`=0. There is no scrolling.
- **Row clear on advance:** when the row clear feature is compiled in (see Configuration), every row advance enters CLR_LINE. CLR_LINE writes `BLANK_GLYPH` to all COLS cells of the new row in ascending address order, then returns to IDLE.
- **Screen clear:** CLR_SCREEN writes `BLANK_GLYPH` to addresses 0..COLS*ROWS-1 in ascending order, then returns to IDLE.
- **Address arithmetic:** `waddr` is computed from a registered row-base value (`row*COLS`) plus `col`, held at 12 bits. No multiplier in the write path.

## Timing
- **Reset values:**
  - `text_en`=0, `waddr`=0, `new_char`=0.
  - `cursor_col`=0, `cursor_row`=0.
  - State IDLE, so `char_ready`=1 and `busy`=0.
- **Mid-clear reset:** reset during a clear aborts the clear immediately. The partially cleared screen is left as is.
- **Registered outputs:** `new_char`, `waddr` and `text_en` are registered. A write caused by a byte accepted in cycle 0 is presented in cycle +1 with `text_en`=1 for exactly one cycle.
- **Cursor update:** the cursor outputs update on the same edge as acceptance, so they are valid in cycle +1.
- **Throughput:** with no row advance involved, one byte per cycle. `char_ready` stays high.
- **Printable byte that wraps the row:**
  - Glyph write in cycle +1; blank writes in cycles +2..+COLS+1.
  - `char_ready` low in cycles +1..+COLS, high in cycle +COLS+1.
- **Newline:**
  - Blank writes in cycles +1..+COLS.
  - `char_ready` low in cycles +1..+COLS-1, high in cycle +COLS.
- **Form feed:**
  - Writes in cycles +1..+2400.
  - `char_ready` low in cycles +1..+2399, high in cycle +2400.
- **Back-to-back after a clear:** a byte accepted in the first cycle `char_ready` is high has its write presented in the next cycle, directly after the last blank write. No gap and no overlap.
- **Input ignored while busy:** `char_valid` is ignored whenever `char_ready`=0. The producer must hold the byte.

## Configuration
- Macro: `TEXT_WRAP_CLEAR_EN`.
- **Defined:** row advances (newline or column overflow) enter CLR_LINE as specified above.
- **Undefined:**
  - Row advances only move the cursor; the CLR_LINE state is not built.
  - Newline produces no write, and `char_ready` stays high.
  - Column overflow behaves like any printable byte: one write, no stall.
  - Form feed behaviour is unchanged.

## Test plan
- **Reset:** assert `rst` mid-cycle → all outputs go to reset values asynchronously. Then send 0x41 → `waddr`=0, `new_char`=1, `text_en` one cycle, cursor (1,0).
- **Back-to-back:** stream "0123" at one byte per cycle from the cursor at (5,2) → writes at 165..168, glyphs 0..3, `char_ready` never low.
- **Column overflow (macro defined):** byte 0x5A at (79,3) → write 319/glyph 0xA, then blanks at 320..399, `char_ready` low 80 cycles, cursor (0,4).
- **Last-row newline:** 0x0A at row 29 → cursor (0,0). With the macro, blanks at 0..79; without it, no writes.
- **Backspace:** 0x08 at (0,7) → no write, cursor unchanged. 0x08 at (10,7) → write 569/`BLANK_GLYPH`, cursor (9,7).
- **Form feed:** 0x0C → 2400 writes at 0..2399, cursor (0,0). Assert `rst` at write 1000 → `text_en` drops immediately, and the next accepted byte writes to address 0.
